// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - hmc-6502 bus responder: wait-stated RAM, vectors, TX FIFO (optional MEM_RESP_BUSERR_EN)
module mem_responder #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_STATES = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] RESET_VEC   = 16'h8000,
    parameter logic [15:0] NMI_VEC     = 16'h8100,
    parameter logic [15:0] IRQ_VEC     = 16'h8200
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    input  logic        mem_req,
    input  logic        mem_we,
    output logic [7:0]  data_in,
    output logic        ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t        r_state;
    state_t        w_next;

    logic [15:0]   r_addr;
    logic [7:0]    r_wdata;
    logic          r_we;
    logic [3:0]    r_cnt;

    logic [7:0]    r_ram  [0:(1<<RAM_AW)-1];
    logic [7:0]    r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_in_ram;
    logic          w_is_txd;
    logic          w_is_stat;
    logic          w_is_vec;
    logic          w_unmapped;
    logic          w_stall;
    logic          w_idle_stall;
    logic          w_cnt_done;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_rdata;
    logic [7:0]    w_vec_byte;
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_in_ram   = ((r_addr >> RAM_AW) == 16'd0);
    assign w_is_txd   = (r_addr == 16'hFE00);
    assign w_is_stat  = (r_addr == 16'hFE01);
    assign w_is_vec   = (r_addr >= 16'hFFFA);
    assign w_unmapped = !(w_in_ram || w_is_txd || w_is_stat || w_is_vec);
    assign w_ram_idx  = r_addr[RAM_AW-1:0];

    // A TXDATA write cannot finish while the FIFO is full; it parks in WAIT.
    assign w_stall      = r_we && w_is_txd && w_full;
    assign w_idle_stall = mem_we && (address == 16'hFE00) && w_full;
    // The counter hits zero on the edge leaving WAIT, so WAIT lasts WAIT_STATES cycles.
    assign w_cnt_done   = (r_cnt <= 4'd1);

    assign w_resp = (r_state == ST_RESP);
    assign w_push = w_resp && r_we && w_is_txd && !w_full;
    assign w_pop  = !w_empty && tx_ready;

    // State register
    always_ff @(posedge ph2) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    if (WAIT_STATES > 0 || w_idle_stall) w_next = ST_WAIT;
                    else                                 w_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (w_cnt_done && !w_stall) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ready = (r_state == ST_RESP);
    end

    // Capture the request and run the wait-state counter
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_addr  <= 16'h0000;
            r_wdata <= 8'h00;
            r_we    <= 1'b0;
            r_cnt   <= 4'd0;
        end else if (r_state == ST_IDLE && mem_req) begin
            r_addr  <= address;
            r_wdata <= data_out;
            r_we    <= mem_we;
            r_cnt   <= 4'(WAIT_STATES);
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Vector byte: low byte at even address
    always_comb begin
        case (r_addr[2:0])
            3'b010:  w_vec_byte = NMI_VEC[7:0];
            3'b011:  w_vec_byte = NMI_VEC[15:8];
            3'b100:  w_vec_byte = RESET_VEC[7:0];
            3'b101:  w_vec_byte = RESET_VEC[15:8];
            3'b110:  w_vec_byte = IRQ_VEC[7:0];
            3'b111:  w_vec_byte = IRQ_VEC[15:8];
            default: w_vec_byte = 8'hFF;
        endcase
    end

    // Read data mux over the address map
    always_comb begin
        w_rdata = 8'hFF;
        if (w_in_ram)       w_rdata = r_ram[w_ram_idx];
        else if (w_is_txd)  w_rdata = 8'h00;
        else if (w_is_stat) w_rdata = {bus_err, 5'b00000, w_empty, w_full};
        else if (w_is_vec)  w_rdata = w_vec_byte;
    end

    // Read data is registered on the edge leaving RESP and held until the next read
    always_ff @(posedge ph2) begin
        if (reset)                data_in <= 8'h00;
        else if (w_resp && !r_we) data_in <= w_rdata;
    end

    // RAM write port; contents deliberately not reset
    always_ff @(posedge ph2) begin
        if (!reset && w_resp && r_we && w_in_ram) r_ram[w_ram_idx] <= r_wdata;
    end

    // FIFO storage
    always_ff @(posedge ph2) begin
        if (!reset && w_push) r_fifo[r_wr_ptr] <= r_wdata;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

`ifdef MEM_RESP_BUSERR_EN
    logic r_bus_err;

    // Sticky unmapped-access flag; a set wins over a STATUS-write clear
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (w_resp) begin
            if (w_unmapped)             r_bus_err <= 1'b1;
            else if (r_we && w_is_stat) r_bus_err <= 1'b0;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder with a behavioural model
module tb_mem_responder;

    localparam int          WS    = 2;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h8000;
    localparam logic [15:0] NV    = 16'h8100;
    localparam logic [15:0] IV    = 16'h8200;
`ifdef MEM_RESP_BUSERR_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic        ph2 = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [7:0]  data_in;
    logic        ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_err;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [7:0] ram_m [0:1023];
    bit         ram_k [0:1023];
    logic [7:0] fifo_q[$];
    bit         exp_berr = 1'b0;

    mem_responder #(
        .RAM_AW(10), .WAIT_STATES(WS), .FIFO_DEPTH(DEPTH),
        .RESET_VEC(RV), .NMI_VEC(NV), .IRQ_VEC(IV)
    ) dut (
        .ph2(ph2), .reset(reset), .address(address), .data_out(data_out),
        .mem_req(mem_req), .mem_we(mem_we), .data_in(data_in), .ready(ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_err(bus_err)
    );

    always #5 ph2 = ~ph2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit is_unmapped(input logic [15:0] a);
        return !(a < 16'd1024 || a == 16'hFE00 || a == 16'hFE01 || a >= 16'hFFFA);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        logic [15:0] v;
        if (a < 16'd1024)  return ram_m[a[9:0]];
        if (a == 16'hFE00) return 8'h00;
        if (a == 16'hFE01) return {exp_berr, 5'b0, fifo_q.size() == 0, fifo_q.size() == DEPTH};
        if (a >= 16'hFFFA) begin
            v = (a < 16'hFFFC) ? NV : (a < 16'hFFFE) ? RV : IV;
            return a[0] ? v[15:8] : v[7:0];
        end
        return 8'hFF;
    endfunction

    task automatic model_commit(input logic [15:0] a, input logic we, input logic [7:0] wd);
        if (we && a < 16'd1024) begin
            ram_m[a[9:0]] = wd;
            ram_k[a[9:0]] = 1'b1;
        end
        if (we && a == 16'hFE00) fifo_q.push_back(wd);
        if (BE && is_unmapped(a)) exp_berr = 1'b1;
        else if (BE && we && a == 16'hFE01) exp_berr = 1'b0;
    endtask

    // Called #1 after an edge; returns edges-to-ready and data_in after completion
    task automatic do_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                             output int lat, output logic [7:0] rd);
        address = a; mem_we = we; data_out = wd; mem_req = 1'b1;
        @(posedge ph2); #1;
        mem_req = 1'b0;
        lat = 1;
        while (ready !== 1'b1 && lat < 100) begin
            @(posedge ph2); #1;
            lat++;
        end
        @(posedge ph2); #1;
        rd = data_in;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge ph2);
        #1;
        n_vec++; if (ready !== 1'b0)    begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_vec++; if (data_in !== 8'h00) begin n_fail++; $display("FAIL reset_data_in got %h want 00", data_in); end
        n_vec++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_vec++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_vec++; if (bus_err !== 1'b0)  begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
        reset = 1'b0;
        @(posedge ph2); #1;
        fifo_q.delete();
        exp_berr = 1'b0;
    endtask

    task automatic test_vectors();
        int lat;
        logic [7:0] rd;
        logic [15:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 16'hFFFC + 16'(i);
            if (i >= 4) a = 16'hFFFA + 16'(i - 4);
            do_access(a, 1'b0, 8'h00, lat, rd);
            n_vec++; if (lat != WS + 1) begin n_fail++; $display("FAIL vec_latency addr %h got %0d want %0d", a, lat, WS + 1); end
            n_vec++; if (rd !== exp_rd(a)) begin n_fail++; $display("FAIL vec_data addr %h got %h want %h", a, rd, exp_rd(a)); end
            model_commit(a, 1'b0, 8'h00);
        end
        // Vector writes are ignored
        do_access(16'hFFFD, 1'b1, 8'h12, lat, rd);
        model_commit(16'hFFFD, 1'b1, 8'h12);
        do_access(16'hFFFD, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== 8'h80) begin n_fail++; $display("FAIL vec_write_ignored got %h want 80", rd); end
    endtask

    task automatic test_ram();
        int lat;
        logic [7:0] rd;
        logic [15:0] a;
        logic [7:0]  d;
        do_access(16'h0123, 1'b1, 8'hA5, lat, rd);
        n_vec++; if (lat != WS + 1) begin n_fail++; $display("FAIL ram_write_latency got %0d want %0d", lat, WS + 1); end
        model_commit(16'h0123, 1'b1, 8'hA5);
        do_access(16'h0123, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL ram_read_0123 got %h want a5", rd); end
        model_commit(16'h0123, 1'b0, 8'h00);
        do_access(16'h5000, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL unmapped_read_5000 got %h want ff", rd); end
        model_commit(16'h5000, 1'b0, 8'h00);
        // Top and bottom of RAM
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? 16'h03FF - 16'(i) : 16'h0000 + 16'(i);
            d = 8'($urandom);
            do_access(a, 1'b1, d, lat, rd);
            model_commit(a, 1'b1, d);
            do_access(a, 1'b0, 8'h00, lat, rd);
            n_vec++; if (rd !== exp_rd(a)) begin n_fail++; $display("FAIL ram_edge addr %h got %h want %h", a, rd, exp_rd(a)); end
        end
    endtask

    task automatic test_fifo_stall();
        int lat;
        logic [7:0] rd;
        logic [7:0] bytes [4];
        bit early;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_access(16'hFE00, 1'b1, bytes[i], lat, rd);
            n_vec++; if (lat != WS + 1) begin n_fail++; $display("FAIL fifo_write_latency %0d got %0d want %0d", i, lat, WS + 1); end
            model_commit(16'hFE00, 1'b1, bytes[i]);
        end
        do_access(16'hFE01, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== exp_rd(16'hFE01)) begin n_fail++; $display("FAIL status_full got %h want %h", rd, exp_rd(16'hFE01)); end
        n_vec++; if ((rd & 8'h7F) !== 8'h01) begin n_fail++; $display("FAIL status_full_low got %h want 01", rd & 8'h7F); end
        // Fifth write must stall until a pop frees a slot
        address = 16'hFE00; mem_we = 1'b1; data_out = 8'h55; mem_req = 1'b1;
        @(posedge ph2); #1;
        mem_req = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ready === 1'b1) early = 1'b1;
            @(posedge ph2); #1;
        end
        n_vec++; if (early) begin n_fail++; $display("FAIL stall_ready got ready=1 want 0 while full"); end
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== fifo_q[0]) begin
            n_fail++; $display("FAIL stall_head got %b/%h want 1/%h", tx_valid, tx_data, fifo_q[0]);
        end
        tx_ready = 1'b1;
        @(posedge ph2); #1;
        tx_ready = 1'b0;
        void'(fifo_q.pop_front());
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge ph2); #1;
            lat++;
        end
        n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got ready=%b want 1", ready); end
        @(posedge ph2); #1;
        model_commit(16'hFE00, 1'b1, 8'h55);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (tx_valid !== 1'b1 || tx_data !== fifo_q[0]) begin
                n_fail++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, fifo_q[0]);
            end
            @(posedge ph2); #1;
            void'(fifo_q.pop_front());
        end
        tx_ready = 1'b0;
        n_vec++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_stream();
        int lat;
        logic [7:0] rd;
        logic [7:0] b;
        tx_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            b = 8'($urandom);
            do_access(16'hFE00, 1'b1, b, lat, rd);
            model_commit(16'hFE00, 1'b1, b);
            n_vec++; if (tx_valid !== 1'b1 || tx_data !== fifo_q[0] || fifo_q.size() != 1) begin
                n_fail++; $display("FAIL stream_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, b);
            end
            @(posedge ph2); #1;
            void'(fifo_q.pop_front());
            n_vec++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL stream_pop_%0d got valid %b want 0", i, tx_valid); end
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [7:0] rd;
        bit seen;
        do_access(16'h0010, 1'b1, 8'h5A, lat, rd);
        model_commit(16'h0010, 1'b1, 8'h5A);
        address = 16'h0010; mem_we = 1'b1; data_out = 8'h3C; mem_req = 1'b1;
        @(posedge ph2); #1;
        mem_req = 1'b0;
        reset = 1'b1;
        @(posedge ph2); #1;
        reset = 1'b0;
        fifo_q.delete();
        exp_berr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ready === 1'b1) seen = 1'b1;
            @(posedge ph2); #1;
        end
        n_vec++; if (seen) begin n_fail++; $display("FAIL abort_ready got ready=1 want 0"); end
        n_vec++; if (data_in !== 8'h00) begin n_fail++; $display("FAIL abort_data_in got %h want 00", data_in); end
        do_access(16'h0010, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL abort_ram got %h want 5a", rd); end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] rd;
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic [15:0] fixed [4];
        fixed = '{16'hFE00, 16'hFE01, 16'hFFFA, 16'hFFFF};
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin a = 16'($urandom_range(0, 31)); we = 1'b1; end
                1: begin a = 16'($urandom_range(0, 31)); we = 1'b0; end
                2: begin a = fixed[$urandom_range(0, 3)]; we = 1'b0; end
                default: begin a = 16'($urandom_range(16'h0400, 16'hFDFF)); we = 1'($urandom); end
            endcase
            do_access(a, we, d, lat, rd);
            n_vec++; if (lat != WS + 1) begin n_fail++; $display("FAIL rand_latency addr %h got %0d want %0d", a, lat, WS + 1); end
            if (!we && !(a < 16'd1024 && !ram_k[a[9:0]])) begin
                n_vec++; if (rd !== exp_rd(a)) begin n_fail++; $display("FAIL rand_read addr %h got %h want %h", a, rd, exp_rd(a)); end
            end
            model_commit(a, we, d);
            n_vec++; if (bus_err !== exp_berr) begin n_fail++; $display("FAIL rand_bus_err addr %h got %b want %b", a, bus_err, exp_berr); end
        end
    endtask

    task automatic test_bus_err();
        int lat;
        logic [7:0] rd;
        do_access(16'hFE01, 1'b1, 8'h00, lat, rd);
        model_commit(16'hFE01, 1'b1, 8'h00);
        n_vec++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL berr_clear0 got %b want 0", bus_err); end
        do_access(16'h7000, 1'b0, 8'h00, lat, rd);
        model_commit(16'h7000, 1'b0, 8'h00);
        n_vec++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL berr_read7000 got %h want ff", rd); end
        n_vec++; if (bus_err !== BE) begin n_fail++; $display("FAIL berr_set got %b want %b", bus_err, BE); end
        do_access(16'hFE01, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== (BE ? 8'h82 : 8'h02)) begin
            n_fail++; $display("FAIL berr_status got %h want %h", rd, BE ? 8'h82 : 8'h02);
        end
        do_access(16'hFE01, 1'b1, 8'h00, lat, rd);
        model_commit(16'hFE01, 1'b1, 8'h00);
        n_vec++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL berr_clear got %b want 0", bus_err); end
        do_access(16'hFE01, 1'b0, 8'h00, lat, rd);
        n_vec++; if (rd !== 8'h02) begin n_fail++; $display("FAIL berr_status_after got %h want 02", rd); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_m[i] = 8'h00;
            ram_k[i] = 1'b0;
        end
        @(posedge ph2); #1;
        test_reset();
        test_vectors();
        test_ram();
        test_fifo_stall();
        test_stream();
        test_reset_abort();
        test_random();
        test_bus_err();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
